// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial wide-word magnitude comparator.
// The one-hot result encoding is {lt, eq, gt}.
package serial_cmp_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } cmp_state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  localparam cmp_res_t CMP_EQ = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};
  localparam cmp_res_t CMP_LT = '{lt: 1'b1, eq: 1'b0, gt: 1'b0};
  localparam cmp_res_t CMP_GT = '{lt: 1'b0, eq: 1'b0, gt: 1'b1};

  // Map any cascade-in pattern to one-hot. Priority is eq > gt > lt; all-zero becomes eq.
  function automatic cmp_res_t normalize_seed(input cmp_res_t seed);
    cmp_res_t r;
    if (seed.eq || (seed == 3'b000)) r = CMP_EQ;
    else if (seed.gt)                r = CMP_GT;
    else                             r = CMP_LT;
    return r;
  endfunction

endpackage

// File: rtl/serial_mag_cmp_if.sv
// Operand and result handshake bundle for serial_mag_cmp.
// Cascade-in wires exist only when SERIAL_CMP_CASCADE_EN is defined.
interface serial_mag_cmp_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_CMP_CASCADE_EN
  logic             cas_lt;
  logic             cas_eq;
  logic             cas_gt;
`endif
  logic             out_valid;
  logic             out_ready;
  logic             lt;
  logic             eq;
  logic             gt;

  // Producer/consumer side of the comparator.
  modport master (
    output in_valid, a, b,
`ifdef SERIAL_CMP_CASCADE_EN
    output cas_lt, cas_eq, cas_gt,
`endif
    output out_ready,
    input  in_ready, out_valid, lt, eq, gt
  );

  // Comparator side.
  modport slave (
    input  in_valid, a, b,
`ifdef SERIAL_CMP_CASCADE_EN
    input  cas_lt, cas_eq, cas_gt,
`endif
    input  out_ready,
    output in_ready, out_valid, lt, eq, gt
  );

endinterface

// File: rtl/cmp4_slice.sv
// Combinational 4-bit magnitude compare with cascade-in: a differing nibble decides,
// otherwise the lower-significance verdict passes through unchanged.
module cmp4_slice
  import serial_cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  cmp_res_t           cas,
  output cmp_res_t           res
);

  always_comb begin
    res = cas;
    if (a > b)      res = CMP_GT;
    else if (a < b) res = CMP_LT;
  end

endmodule

// File: rtl/serial_mag_cmp.sv
// Sequential WIDTH-bit magnitude comparator: one 4-bit slice per cycle, LSB first.
// Optional cascade-in seeding is enabled by defining SERIAL_CMP_CASCADE_EN.
module serial_mag_cmp
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  serial_mag_cmp_if.slave bus
);

  localparam int NSLICES = WIDTH / SLICE_W;
  localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

  cmp_state_t       state;
  logic [IDXW-1:0]  idx;
  cmp_res_t         acc;
  cmp_res_t         res;
  logic             out_valid;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [SLICE_W-1:0] a_nib;
  logic [SLICE_W-1:0] b_nib;
  cmp_res_t           slice_res;
  cmp_res_t           seed;

  assign a_nib = a_q[SLICE_W*idx +: SLICE_W];
  assign b_nib = b_q[SLICE_W*idx +: SLICE_W];

`ifdef SERIAL_CMP_CASCADE_EN
  assign seed = normalize_seed('{lt: bus.cas_lt, eq: bus.cas_eq, gt: bus.cas_gt});
`else
  assign seed = CMP_EQ;
`endif

  cmp4_slice u_slice (
    .a   (a_nib),
    .b   (b_nib),
    .cas (acc),
    .res (slice_res)
  );

  assign bus.in_ready  = (state == S_IDLE) & ~rst;
  assign bus.out_valid = out_valid;
  assign bus.lt        = res.lt;
  assign bus.eq        = res.eq;
  assign bus.gt        = res.gt;

  // Control FSM; the result is registered on the final slice and held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      acc       <= '0;
      res       <= '0;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            idx   <= '0;
            acc   <= seed;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= slice_res;
          if (idx == LAST_IDX) begin
            res       <= slice_res;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed self-checking bench for serial_mag_cmp (WIDTH=16 main instance, WIDTH=4 corner).
// Cascade vectors run only when SERIAL_CMP_CASCADE_EN is defined.
module tb_serial_mag_cmp;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  always #5 clk = ~clk;

  serial_mag_cmp_if #(.WIDTH(16)) bus ();
  serial_mag_cmp_if #(.WIDTH(4))  bus4 ();

  serial_mag_cmp #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_mag_cmp #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operand pair across a single accepting edge.
  task automatic apply_stimulus(input logic [15:0] av, input logic [15:0] bv, input logic rdy);
    check_output("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = rdy;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count cycles until out_valid, bounded so a dead DUT still reaches the summary.
  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic full_compare(input string tag, input logic [15:0] av, input logic [15:0] bv,
                              input logic [2:0] exp_res);
    apply_stimulus(av, bv, 1'b1);
    wait_result(lat);
    check_output({tag, "_latency"}, 32'(lat), 32'd4);
    check_output({tag, "_result"}, 32'({bus.lt, bus.eq, bus.gt}), 32'(exp_res));
    @(posedge clk);
    #1;
    check_output({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check_output({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.out_ready = 1'b1;
`ifdef SERIAL_CMP_CASCADE_EN
    bus.cas_lt  = 1'b0;
    bus.cas_eq  = 1'b0;
    bus.cas_gt  = 1'b0;
    bus4.cas_lt = 1'b0;
    bus4.cas_eq = 1'b0;
    bus4.cas_gt = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_result", 32'({bus.lt, bus.eq, bus.gt}), 32'd0);
    rst = 1'b0;
    #1;
    check_output("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Equal, MSB override, LSB-only difference, mixed nibbles
    full_compare("eq_1234", 16'h1234, 16'h1234, 3'b010);
    full_compare("gt_msb", 16'h8000, 16'h7FFF, 3'b001);
    full_compare("lt_lsb", 16'h5551, 16'h5552, 3'b100);
    full_compare("lt_mid", 16'h00F0, 16'h0F00, 3'b100);

    // Backpressure: result held, second request ignored
    apply_stimulus(16'h1234, 16'h1234, 1'b0);
    wait_result(lat);
    check_output("bp_latency", 32'(lat), 32'd4);
    bus.a        = 16'h0000;
    bus.b        = 16'hFFFF;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_output("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
      check_output("bp_result_held", 32'({bus.lt, bus.eq, bus.gt}), 32'b010);
      check_output("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("bp_release_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset while in RUN with idx==2
    apply_stimulus(16'h1234, 16'h1235, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_output("mid_run_no_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    #1;
    check_output("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_output("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    check_output("mid_rst_idle", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_output("no_stale_result", 32'(bus.out_valid), 32'd0);
    end
    full_compare("lt_after_rst", 16'h0000, 16'hFFFF, 3'b100);

    // WIDTH=4: a single RUN cycle
    bus4.a        = 4'h9;
    bus4.b        = 4'h3;
    bus4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    check_output("w4_not_yet", 32'(bus4.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_output("w4_valid", 32'(bus4.out_valid), 32'd1);
    check_output("w4_gt", 32'({bus4.lt, bus4.eq, bus4.gt}), 32'b001);
    @(posedge clk);
    #1;
    check_output("w4_drop", 32'(bus4.out_valid), 32'd0);

`ifdef SERIAL_CMP_CASCADE_EN
    // Cascade seeding
    bus.cas_gt = 1'b1;
    full_compare("cas_gt_seed", 16'hABCD, 16'hABCD, 3'b001);
    bus.cas_gt = 1'b0;
    bus.cas_eq = 1'b1;
    bus.cas_lt = 1'b1;
    full_compare("cas_eq_prio", 16'hABCD, 16'hABCD, 3'b010);
    bus.cas_eq = 1'b0;
    full_compare("cas_lt_overridden", 16'h0001, 16'h0000, 3'b001);
    full_compare("cas_lt_equal", 16'h4321, 16'h4321, 3'b100);
    bus.cas_lt = 1'b0;
    full_compare("cas_zero_seed", 16'h4321, 16'h4321, 3'b010);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
